reg_file_banked: RTL and testbench



---
 rtl/reg_file_banked_pkg.sv | 68 ++++++
 rtl/reg_file_banked_trap_seq.sv | 82 ++++++++
 rtl/reg_file_banked.sv | 189 ++++++++++++++++++
 tb/tb_reg_file_banked.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_banked_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : reg_file_banked_pkg
// Purpose  : Shared types and helpers for the banked CPU register file:
//            register map enum, partial-write mask widths, STATUS layout,
//            trap sequencer state encoding, mask and special-index helpers.
// Ports    : none (package)
// Options  : BANKED_SP_EN (consumed by reg_file_banked, not by this package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package reg_file_banked_pkg;

   // Fixed 16-entry map; special registers follow the general registers.
   typedef enum logic [3:0] {
      R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10,
      R_STATUS, R_SP, R_LR, R_PCLINK, R_PC
   } reg_e;

   typedef enum logic [1:0] {
      LS8  = 2'd0,
      LS16 = 2'd1,
      LS24 = 2'd2,
      FULL = 2'd3
   } reg_mask_e;

   typedef enum logic {
      USER       = 1'b0,
      SUPERVISOR = 1'b1
   } mode_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_status_t;

   typedef struct packed {
      alu_status_t alu_status;
      logic        imask;
      mode_e       mode;
   } status_t;

   localparam int      STATUS_W     = $bits(status_t);
   localparam status_t RESET_STATUS = '{alu_status: '0, imask: 1'b1, mode: SUPERVISOR};

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      TRAP_SAVE = 2'd1,
      TRAP_VEC  = 2'd2
   } trap_state_e;

   function automatic logic [31:0] mask_w(input reg_mask_e m);
      case (m)
         LS8:     return 32'h0000_00FF;
         LS16:    return 32'h0000_FFFF;
         LS24:    return 32'h00FF_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Index of a special register when the file holds num_gpr general registers.
   function automatic int special_idx(input int num_gpr, input reg_e r);
      return num_gpr + (int'(r) - int'(R_STATUS));
   endfunction

endpackage : reg_file_banked_pkg
`default_nettype wire

// File: rtl/reg_file_banked_trap_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : reg_file_banked_trap_seq
// Purpose  : Trap entry / return sequencer. Owns the trap FSM and the saved
//            STATUS copy; emits load strobes consumed by the register file.
// Ports    : clk, rst_n         - clock, async active-low reset
//            i_trap_req         - trap entry request (accepted in IDLE)
//            i_rti_req          - return from trap (accepted in IDLE)
//            i_status           - current STATUS, captured on trap entry
//            o_busy             - trap sequence in progress
//            o_trap_ack         - high for the single TRAP_VEC cycle
//            o_lr_save          - LR <= PC this edge
//            o_vec_load         - PC <= vector, enter supervisor this edge
//            o_rti_load         - PC <= LR, STATUS <= saved this edge
//            o_saved_status     - STATUS captured at trap entry
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module reg_file_banked_trap_seq
   import reg_file_banked_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    i_trap_req,
   input  logic    i_rti_req,
   input  status_t i_status,
   output logic    o_busy,
   output logic    o_trap_ack,
   output logic    o_lr_save,
   output logic    o_vec_load,
   output logic    o_rti_load,
   output status_t o_saved_status
);

   trap_state_e r_state;
   logic        r_busy;
   logic        r_trap_ack;
   status_t     r_saved_status;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_busy         <= 1'b0;
         r_trap_ack     <= 1'b0;
         r_saved_status <= RESET_STATUS;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_trap_req) begin
                  r_state        <= TRAP_SAVE;
                  r_busy         <= 1'b1;
                  r_saved_status <= i_status;
               end
            end
            TRAP_SAVE: begin
               r_state    <= TRAP_VEC;
               r_trap_ack <= 1'b1;
            end
            TRAP_VEC: begin
               r_state    <= IDLE;
               r_busy     <= 1'b0;
               r_trap_ack <= 1'b0;
            end
            default: begin
               r_state    <= IDLE;
               r_busy     <= 1'b0;
               r_trap_ack <= 1'b0;
            end
         endcase
      end
   end

   // The vector load lands on the TRAP_VEC exit edge, so the new PC and
   // mode become visible the cycle after trap_ack.
   assign o_lr_save      = (r_state == IDLE) && i_trap_req;
   assign o_vec_load     = (r_state == TRAP_VEC);
   assign o_rti_load     = (r_state == IDLE) && !i_trap_req && i_rti_req;
   assign o_busy         = r_busy;
   assign o_trap_ack     = r_trap_ack;
   assign o_saved_status = r_saved_status;

endmodule : reg_file_banked_trap_seq
`default_nettype wire

// File: rtl/reg_file_banked.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : reg_file_banked
// Purpose  : Parametrised CPU register file: NUM_GPR general registers plus
//            STATUS, SP, LR, PCLINK and PC; masked partial writes,
//            privilege-checked STATUS writes, link-on-jump through PCLINK,
//            and a trap entry / return sequencer.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            i_rd_sel / o_rd_data       - NUM_RD combinational read ports
//            i_wr_en, i_wr_sel,
//            i_wr_mask, i_wr_data       - single masked write port
//            i_pc_inc                   - PC += 1
//            i_flags_we, i_flags_in     - ALU flag update
//            i_trap_req, i_trap_vector  - trap entry
//            i_rti_req                  - return from trap
//            o_trap_ack, o_busy         - trap sequencer status
//            o_status_out, o_pc_out     - current STATUS and PC
// Options  : BANKED_SP_EN - separate user/supervisor stack pointers
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module reg_file_banked
   import reg_file_banked_pkg::*;
#(
   parameter  int WORD_W   = 32,
   parameter  int NUM_GPR  = 11,
   parameter  int NUM_RD   = 2,
   parameter  int RESET_PC = 0,
   localparam int IDX_W    = $clog2(NUM_GPR + 5)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_RD-1:0][IDX_W-1:0]   i_rd_sel,
   output logic [NUM_RD-1:0][WORD_W-1:0]  o_rd_data,
   input  logic                           i_wr_en,
   input  logic [IDX_W-1:0]               i_wr_sel,
   input  reg_mask_e                      i_wr_mask,
   input  logic [WORD_W-1:0]              i_wr_data,
   input  logic                           i_pc_inc,
   input  logic                           i_flags_we,
   input  alu_status_t                    i_flags_in,
   input  logic                           i_trap_req,
   input  logic [WORD_W-1:0]              i_trap_vector,
   input  logic                           i_rti_req,
   output logic                           o_trap_ack,
   output logic                           o_busy,
   output status_t                        o_status_out,
   output logic [WORD_W-1:0]              o_pc_out
);

   localparam int NUM_IDX    = NUM_GPR + 5;
   localparam int IDX_STATUS = special_idx(NUM_GPR, R_STATUS);
   localparam int IDX_SP     = special_idx(NUM_GPR, R_SP);
   localparam int IDX_LR     = special_idx(NUM_GPR, R_LR);
   localparam int IDX_PCLINK = special_idx(NUM_GPR, R_PCLINK);
   localparam int IDX_PC     = special_idx(NUM_GPR, R_PC);

   logic [WORD_W-1:0] r_gpr [NUM_GPR];
   logic [WORD_W-1:0] r_lr;
   logic [WORD_W-1:0] r_pc;
   status_t           r_status;

   logic [WORD_W-1:0] w_sp;
   logic [WORD_W-1:0] w_view [NUM_IDX];
   logic [31:0]       w_mask32;
   logic [WORD_W-1:0] w_mask;
   logic [WORD_W-1:0] w_old;
   logic [WORD_W-1:0] w_merged;
   status_t           w_status_wr;
   status_t           w_saved_status;
   logic              w_busy, w_trap_ack, w_lr_save, w_vec_load, w_rti_load;
   logic              w_normal, w_wr;
   logic              w_wr_gpr, w_wr_status, w_wr_sp, w_wr_lr, w_wr_pclink, w_wr_pc;

   reg_file_banked_trap_seq u_trap_seq (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_trap_req     (i_trap_req),
      .i_rti_req      (i_rti_req),
      .i_status       (r_status),
      .o_busy         (w_busy),
      .o_trap_ack     (w_trap_ack),
      .o_lr_save      (w_lr_save),
      .o_vec_load     (w_vec_load),
      .o_rti_load     (w_rti_load),
      .o_saved_status (w_saved_status)
   );

   // Architectural view of every index; PCLINK aliases PC on reads.
   always_comb begin
      for (int i = 0; i < NUM_GPR; i++) w_view[i] = r_gpr[i];
      w_view[IDX_STATUS] = WORD_W'(r_status);
      w_view[IDX_SP]     = w_sp;
      w_view[IDX_LR]     = r_lr;
      w_view[IDX_PCLINK] = r_pc;
      w_view[IDX_PC]     = r_pc;
   end

   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         o_rd_data[p] = (int'(i_rd_sel[p]) < NUM_IDX) ? w_view[i_rd_sel[p]] : '0;
      end
   end

   // Ordinary updates only happen in IDLE with no trap/rti request this cycle.
   assign w_normal    = !w_busy && !i_trap_req && !i_rti_req;
   assign w_wr        = w_normal && i_wr_en;
   assign w_wr_gpr    = w_wr && (int'(i_wr_sel) < NUM_GPR);
   assign w_wr_status = w_wr && (int'(i_wr_sel) == IDX_STATUS);
   assign w_wr_sp     = w_wr && (int'(i_wr_sel) == IDX_SP);
   assign w_wr_lr     = w_wr && (int'(i_wr_sel) == IDX_LR);
   assign w_wr_pclink = w_wr && (int'(i_wr_sel) == IDX_PCLINK);
   assign w_wr_pc     = w_wr && (int'(i_wr_sel) == IDX_PC);

   assign w_mask32 = mask_w(i_wr_mask);
   assign w_mask   = w_mask32[WORD_W-1:0];
   assign w_old    = (int'(i_wr_sel) < NUM_IDX) ? w_view[i_wr_sel] : '0;
   assign w_merged = (w_old & ~w_mask) | (i_wr_data & w_mask);

   // User mode may only change the ALU flags through a STATUS write.
   always_comb begin
      w_status_wr = status_t'(w_merged[STATUS_W-1:0]);
      if (r_status.mode == USER) begin
         w_status_wr.imask = r_status.imask;
         w_status_wr.mode  = r_status.mode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
         r_lr     <= '0;
         r_pc     <= WORD_W'(RESET_PC);
         r_status <= RESET_STATUS;
      end else if (w_lr_save) begin
         r_lr <= r_pc;
      end else if (w_vec_load) begin
         r_pc           <= i_trap_vector;
         r_status.mode  <= SUPERVISOR;
         r_status.imask <= 1'b1;
      end else if (w_rti_load) begin
         r_pc     <= r_lr;
         r_status <= w_saved_status;
      end else if (w_normal) begin
         if (w_wr_gpr) r_gpr[i_wr_sel] <= w_merged;

         if (w_wr_lr)          r_lr <= w_merged;
         else if (w_wr_pclink) r_lr <= r_pc;

         if (w_wr_pc || w_wr_pclink) r_pc <= w_merged;
         else if (i_pc_inc)          r_pc <= r_pc + WORD_W'(1);

         if (w_wr_status)     r_status            <= w_status_wr;
         else if (i_flags_we) r_status.alu_status <= i_flags_in;
      end
   end

`ifdef BANKED_SP_EN
   logic [WORD_W-1:0] r_sp_usr;
   logic [WORD_W-1:0] r_sp_svc;

   assign w_sp = (r_status.mode == SUPERVISOR) ? r_sp_svc : r_sp_usr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sp_usr <= '0;
         r_sp_svc <= '0;
      end else if (w_wr_sp) begin
         if (r_status.mode == SUPERVISOR) r_sp_svc <= w_merged;
         else                             r_sp_usr <= w_merged;
      end
   end
`else
   logic [WORD_W-1:0] r_sp;

   assign w_sp = r_sp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_sp <= '0;
      else if (w_wr_sp) r_sp <= w_merged;
   end
`endif

   assign o_busy       = w_busy;
   assign o_trap_ack   = w_trap_ack;
   assign o_status_out = r_status;
   assign o_pc_out     = r_pc;

endmodule : reg_file_banked
`default_nettype wire

// File: tb/tb_reg_file_banked.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_reg_file_banked
// Purpose  : Self-checking bench for reg_file_banked (default parameters).
//            Table of write/read vectors plus hand sequences for trap entry,
//            return, stack banking and reset during a trap.
// Options  : BANKED_SP_EN - selects banked stack-pointer expectations
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_reg_file_banked;
   import reg_file_banked_pkg::*;

   localparam int WORD_W = 32;
   localparam int NUM_RD = 2;
   localparam int IDX_W  = 4;

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic [NUM_RD-1:0][IDX_W-1:0]  rd_sel;
   logic [NUM_RD-1:0][WORD_W-1:0] rd_data;
   logic                          wr_en;
   logic [IDX_W-1:0]              wr_sel;
   reg_mask_e                     wr_mask;
   logic [WORD_W-1:0]             wr_data;
   logic                          pc_inc;
   logic                          flags_we;
   alu_status_t                   flags_in;
   logic                          trap_req;
   logic [WORD_W-1:0]             trap_vector;
   logic                          rti_req;
   logic                          trap_ack;
   logic                          busy;
   status_t                       status_out;
   logic [WORD_W-1:0]             pc_out;

   always #5 clk = ~clk;

   reg_file_banked #(.WORD_W(32), .NUM_GPR(11), .NUM_RD(2), .RESET_PC(0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_rd_sel      (rd_sel),
      .o_rd_data     (rd_data),
      .i_wr_en       (wr_en),
      .i_wr_sel      (wr_sel),
      .i_wr_mask     (wr_mask),
      .i_wr_data     (wr_data),
      .i_pc_inc      (pc_inc),
      .i_flags_we    (flags_we),
      .i_flags_in    (flags_in),
      .i_trap_req    (trap_req),
      .i_trap_vector (trap_vector),
      .i_rti_req     (rti_req),
      .o_trap_ack    (trap_ack),
      .o_busy        (busy),
      .o_status_out  (status_out),
      .o_pc_out      (pc_out)
   );

   typedef struct {
      logic        wr_en;
      logic [3:0]  sel;
      reg_mask_e   mask;
      logic [31:0] data;
      logic        pc_inc;
      logic        flags_we;
      logic [3:0]  flags;
      logic [3:0]  s0;
      logic [31:0] e0;
      logic [3:0]  s1;
      logic [31:0] e1;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      wr_en    = 1'b0;
      pc_inc   = 1'b0;
      flags_we = 1'b0;
      trap_req = 1'b0;
      rti_req  = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [3:0] idx, input logic [31:0] exp);
      rd_sel[0] = idx;
      #1;
      chk(nm, rd_data[0], exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Index map: R0..R10, STATUS=11, SP=12, LR=13, PCLINK=14, PC=15.
      // STATUS bits: [5:2] flags, [1] imask, [0] mode (1=supervisor).
      vecs[0]  = '{1'b1, 4'd3,  FULL, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 4'd3,  32'hAABBCCDD, 4'd0,  32'h0};
      vecs[1]  = '{1'b1, 4'd3,  LS16, 32'h11223344, 1'b0, 1'b0, 4'h0, 4'd3,  32'hAABB3344, 4'd15, 32'h0};
      vecs[2]  = '{1'b1, 4'd3,  LS8,  32'h99887766, 1'b0, 1'b0, 4'h0, 4'd3,  32'hAABB3366, 4'd2,  32'h0};
      vecs[3]  = '{1'b1, 4'd3,  LS24, 32'h12345678, 1'b0, 1'b0, 4'h0, 4'd3,  32'hAA345678, 4'd4,  32'h0};
      vecs[4]  = '{1'b1, 4'd10, FULL, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 4'd10, 32'hDEADBEEF, 4'd3,  32'hAA345678};
      vecs[5]  = '{1'b1, 4'd15, FULL, 32'h00000100, 1'b0, 1'b0, 4'h0, 4'd15, 32'h00000100, 4'd14, 32'h00000100};
      vecs[6]  = '{1'b1, 4'd14, FULL, 32'h00000200, 1'b1, 1'b0, 4'h0, 4'd15, 32'h00000200, 4'd13, 32'h00000100};
      vecs[7]  = '{1'b0, 4'd0,  FULL, 32'h0,        1'b1, 1'b0, 4'h0, 4'd15, 32'h00000201, 4'd13, 32'h00000100};
      vecs[8]  = '{1'b0, 4'd0,  FULL, 32'h0,        1'b0, 1'b1, 4'hA, 4'd11, 32'h0000002B, 4'd15, 32'h00000201};
      vecs[9]  = '{1'b1, 4'd11, FULL, 32'h00000000, 1'b0, 1'b1, 4'hF, 4'd11, 32'h00000000, 4'd13, 32'h00000100};
      vecs[10] = '{1'b1, 4'd11, FULL, 32'h0000003F, 1'b0, 1'b0, 4'h0, 4'd11, 32'h0000003C, 4'd12, 32'h0};
      vecs[11] = '{1'b0, 4'd0,  FULL, 32'h0,        1'b0, 1'b1, 4'h5, 4'd11, 32'h00000014, 4'd3,  32'hAA345678};
      vecs[12] = '{1'b1, 4'd12, FULL, 32'h00001000, 1'b0, 1'b0, 4'h0, 4'd12, 32'h00001000, 4'd11, 32'h00000014};
      vecs[13] = '{1'b1, 4'd15, FULL, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 4'd15, 32'hFFFFFFFF, 4'd14, 32'hFFFFFFFF};
      vecs[14] = '{1'b0, 4'd0,  FULL, 32'h0,        1'b1, 1'b0, 4'h0, 4'd15, 32'h00000000, 4'd13, 32'h00000100};
      vecs[15] = '{1'b1, 4'd13, LS8,  32'h00000077, 1'b0, 1'b0, 4'h0, 4'd13, 32'h00000177, 4'd15, 32'h0};
      vecs[16] = '{1'b1, 4'd15, FULL, 32'h00000040, 1'b1, 1'b0, 4'h0, 4'd15, 32'h00000040, 4'd13, 32'h00000177};

      rst_n       = 1'b0;
      rd_sel      = '0;
      wr_sel      = '0;
      wr_mask     = FULL;
      wr_data     = '0;
      flags_in    = '0;
      trap_vector = '0;
      idle_in();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_ack", {31'b0, trap_ack}, 32'h0);
      chk("rst_status_out", {26'b0, status_out}, 32'h3);
      chk("rst_pc_out", pc_out, 32'h0);
      for (int i = 0; i < 16; i++) begin
         rd_chk($sformatf("rst_idx%0d", i), 4'(i), (i == 11) ? 32'h3 : 32'h0);
      end

      // Table-driven writes and reads
      for (int i = 0; i < NVEC; i++) begin
         wr_en     = vecs[i].wr_en;
         wr_sel    = vecs[i].sel;
         wr_mask   = vecs[i].mask;
         wr_data   = vecs[i].data;
         pc_inc    = vecs[i].pc_inc;
         flags_we  = vecs[i].flags_we;
         flags_in  = alu_status_t'(vecs[i].flags);
         rd_sel[0] = vecs[i].s0;
         rd_sel[1] = vecs[i].s1;
         step();
         idle_in();
         chk($sformatf("vec%0d_p0", i), rd_data[0], vecs[i].e0);
         chk($sformatf("vec%0d_p1", i), rd_data[1], vecs[i].e1);
      end

      // No bypass: old value visible during the write cycle
      wr_en = 1'b1; wr_sel = 4'd5; wr_mask = FULL; wr_data = 32'h123;
      rd_sel[1] = 4'd5;
      #1;
      chk("nobypass_before", rd_data[1], 32'h0);
      step();
      wr_en = 1'b0;
      chk("nobypass_after", rd_data[1], 32'h123);

      // Trap entry at PC=0x40 (user, imask=0, flags=5), write held while busy
      trap_vector = 32'h800;
      trap_req = 1'b1;
      wr_en = 1'b1; wr_sel = 4'd0; wr_mask = FULL; wr_data = 32'h55;
      step();
      trap_req = 1'b0;
      chk("trap_save_busy", {31'b0, busy}, 32'h1);
      chk("trap_save_ack", {31'b0, trap_ack}, 32'h0);
      chk("trap_save_pc", pc_out, 32'h40);
      rd_chk("trap_save_lr", 4'd13, 32'h40);
      step();
      chk("trap_vec_busy", {31'b0, busy}, 32'h1);
      chk("trap_vec_ack", {31'b0, trap_ack}, 32'h1);
      chk("trap_vec_pc_old", pc_out, 32'h40);
      chk("trap_vec_status_old", {26'b0, status_out}, 32'h14);
      step();
      wr_en = 1'b0;
      chk("trap_done_busy", {31'b0, busy}, 32'h0);
      chk("trap_done_ack", {31'b0, trap_ack}, 32'h0);
      chk("trap_done_pc", pc_out, 32'h800);
      chk("trap_done_status", {26'b0, status_out}, 32'h17);
      rd_chk("trap_done_lr", 4'd13, 32'h40);
      rd_chk("trap_busy_write_ignored", 4'd0, 32'h0);

      rti_req = 1'b1;
      step();
      rti_req = 1'b0;
      chk("rti_pc", pc_out, 32'h40);
      chk("rti_status", {26'b0, status_out}, 32'h14);
      chk("rti_busy", {31'b0, busy}, 32'h0);

      // Stack pointer across a trap (user SP currently 0x1000)
      trap_req = 1'b1;
      step();
      trap_req = 1'b0;
      step();
      step();
`ifdef BANKED_SP_EN
      rd_chk("sp_in_trap", 4'd12, 32'h0);
`else
      rd_chk("sp_in_trap", 4'd12, 32'h1000);
`endif
      wr_en = 1'b1; wr_sel = 4'd12; wr_mask = FULL; wr_data = 32'h2000;
      step();
      wr_en = 1'b0;
      rd_chk("sp_written_svc", 4'd12, 32'h2000);
      rti_req = 1'b1;
      step();
      rti_req = 1'b0;
`ifdef BANKED_SP_EN
      rd_chk("sp_after_rti", 4'd12, 32'h1000);
`else
      rd_chk("sp_after_rti", 4'd12, 32'h2000);
`endif

      // Reset asserted during TRAP_SAVE
      trap_vector = 32'h900;
      trap_req = 1'b1;
      step();
      trap_req = 1'b0;
      chk("rstmid_busy_pre", {31'b0, busy}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy", {31'b0, busy}, 32'h0);
      chk("rstmid_ack", {31'b0, trap_ack}, 32'h0);
      chk("rstmid_pc", pc_out, 32'h0);
      chk("rstmid_status", {26'b0, status_out}, 32'h3);
      rd_chk("rstmid_lr", 4'd13, 32'h0);
      rd_chk("rstmid_r3", 4'd3, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      chk("rstmid_after_busy", {31'b0, busy}, 32'h0);
      chk("rstmid_after_pc", pc_out, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_reg_file_banked
`default_nettype wire
